// File: rtl/cla_multiword_sequencer.sv
// Wide unsigned adder built from one reused 4-bit carry-lookahead slice, one nibble per clock.
// Optional OVERFLOW_FLAG_EN adds a signed-overflow output (ovf) captured with the final nibble.
module cla_multiword_sequencer #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
   output logic         ovf,
`endif
   output logic         cout,
   output logic         busy
);

   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      a_q, b_q, sum_q;
   logic              carry_q, cout_q, ovf_q;
   logic [IDXW-1:0]   idx_q;
   logic              last_nib;
   logic [3:0]        p, g, s4;
   logic [4:0]        c;

   assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

   // Operand registers shift right each RUN cycle, so the active nibble is always [3:0].
   always_comb begin
      p    = a_q[3:0] ^ b_q[3:0];
      g    = a_q[3:0] & b_q[3:0];
      c[0] = carry_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s4   = p ^ c[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_d = S_RUN;
         S_RUN:   if (last_nib)  state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q == S_RUN) || (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               a_q     <= a;
               b_q     <= b;
               carry_q <= cin;
               idx_q   <= '0;
            end
            S_RUN: begin
               sum_q[4*idx_q +: 4] <= s4;
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               carry_q <= c[4];
               idx_q   <= idx_q + 1'b1;
               if (last_nib) begin
                  cout_q <= c[4];
                  ovf_q  <= c[3] ^ c[4];
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Scoreboard bench: driver pushes a + b + cin model results, negedge monitor pops on each retired result.
module tb_cla_multiword_sequencer;
   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct {
      logic [W:0] res;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
   logic in_ready, out_valid, cout, busy, ovf;
   logic [W-1:0] a = '0, b = '0, sum;
   // single-nibble instance
   logic in_valid1 = 1'b0, cin1 = 1'b0;
   logic in_ready1, out_valid1, cout1, busy1, ovf1;
   logic [3:0] a1 = '0, b1 = '0, sum1;

   exp_t q[$];
   int n_vec = 0, n_err = 0, n_push = 0, n_out = 0;
   bit rnd_bp = 0;

   always #5 clk = ~clk;

   cla_multiword_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum),
`ifdef OVERFLOW_FLAG_EN
      .ovf(ovf),
`endif
      .cout(cout), .busy(busy));

   cla_multiword_sequencer #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(1'b1),
      .sum(sum1),
`ifdef OVERFLOW_FLAG_EN
      .ovf(ovf1),
`endif
      .cout(cout1), .busy(busy1));

`ifndef OVERFLOW_FLAG_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      exp_t e;
      e.res = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      return e;
   endfunction

   // Presents operands and holds in_valid until the DUT accepts them.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int k = 0;
      a = x; b = y; cin = ci; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 200) begin k++; @(negedge clk); end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      q.push_back(model(x, y, ci));
      n_push++;
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int k = 0;
      @(negedge clk);
      while (!out_valid && k < 100) begin k++; @(negedge clk); end
      if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || !in_ready) && k < 400) begin k++; @(negedge clk); end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         n_out++;
         if (q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
         else begin
            e = q.pop_front();
            chk("sum_cout", 64'({cout, sum}), 64'(e.res));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
         end
      end
   end

   always @(posedge clk) if (rnd_bp) #1 out_ready = 1'($urandom_range(0, 1));

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t ea;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum_cout", 64'({cout, sum}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // carry ripple plus latency
      send(16'h00FF, 16'h0001, 1'b0);
      for (int i = 1; i <= N; i++) begin
         @(negedge clk);
         chk("lat_low", 64'(out_valid), 64'd0);
         if (i == 1) chk("run_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      chk("lat_high", 64'(out_valid), 64'd1);
      chk("ripple_sum", 64'({cout, sum}), 64'h0_0100);
      @(negedge clk);
      chk("valid_drop", 64'(out_valid), 64'd0);
      drain();

      send(16'hFFFF, 16'h0000, 1'b1); drain();
      send(16'h1234, 16'h4321, 1'b1); drain();

      // backpressure with in_valid held high throughout
      out_ready = 1'b0;
      send(16'hBEEF, 16'h1111, 1'b0);
      ea = model(16'hBEEF, 16'h1111, 1'b0);
      a = 16'h0F0F; b = 16'hF0F1; cin = 1'b1; in_valid = 1'b1;
      wait_out();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_sum_cout", 64'({cout, sum}), 64'(ea.res));
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      send(16'h0F0F, 16'hF0F1, 1'b1);
      drain();

      // reset in the middle of RUN
      send(16'hAAAA, 16'h5555, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      void'(q.pop_back()); n_push--;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_sum_cout", 64'({cout, sum}), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      repeat (6) begin
         @(negedge clk);
         chk("mid_rst_no_out", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;

      // signed overflow corners
      send(16'h7FFF, 16'h0001, 1'b0); drain();
      send(16'h8000, 16'h8000, 1'b0); drain();
      send(16'h0003, 16'h0004, 1'b0); drain();

      // random operands with random gaps and backpressure
      rnd_bp = 1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1 send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      rnd_bp = 0;
      @(posedge clk); #2 out_ready = 1'b1;
      drain();

      // single-nibble build
      in_valid1 = 1'b1; a1 = 4'hB; b1 = 4'h6; cin1 = 1'b0;
      @(negedge clk);
      chk("n1_in_ready", 64'(in_ready1), 64'd1);
      @(posedge clk); #1 in_valid1 = 1'b0;
      @(negedge clk);
      chk("n1_run_valid", 64'(out_valid1), 64'd0);
      @(negedge clk);
      chk("n1_valid", 64'(out_valid1), 64'd1);
      chk("n1_sum_cout", 64'({cout1, sum1}), 64'h11);
      chk("n1_ovf", 64'(ovf1), 64'd0);
      @(negedge clk);
      chk("n1_valid_drop", 64'(out_valid1), 64'd0);

      chk("result_count", 64'(n_out), 64'(n_push));
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
